// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory-stage load/store unit.
//
// Takes the M-stage control/data from the EX/M pipeline register and runs one
// req/ack transaction per load/store on the data-memory port.  Stores get
// byte enables and lane-replicated data.  Loads get the selected byte/half
// sign- or zero-extended.  stall_M holds the front of the pipeline until
// the access completes or times out.
//
// Optional feature: define MISALIGN_TRAP_EN to add the misalign_M output.
// Misaligned accesses then complete without touching memory.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   memRead_M, memWrite_M      load / store request (store wins if both set)
//   mode_M[2:0]                funct3 access size/signedness
//   alu_rsl_M[31:0]            effective byte address
//   write_Data_M[31:0]         store data (value in LSBs)
//   stall_M                    freeze IF..M while high
//   load_data_M[31:0]          extended load result
//   load_valid_M               1-cycle pulse, load_data_M valid
//   bus_err_M                  1-cycle pulse, access aborted on timeout
//   misalign_M                 1-cycle pulse, misaligned access (MISALIGN_TRAP_EN only)
//   dmem_req/we/addr/be/wdata  memory request, held stable until ack
//   dmem_ack, dmem_rdata       memory completion and read word

module mem_stage_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        memRead_M,
    input  logic        memWrite_M,
    input  logic [2:0]  mode_M,
    input  logic [31:0] alu_rsl_M,
    input  logic [31:0] write_Data_M,
    output logic        stall_M,
    output logic [31:0] load_data_M,
    output logic        load_valid_M,
    output logic        bus_err_M,
`ifdef MISALIGN_TRAP_EN
    output logic        misalign_M,
`endif
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e          r_state;
    state_e          w_state_next;

    logic            r_we;
    logic            r_rd;
    logic            r_err;
    logic [29:0]     r_waddr;
    logic [1:0]      r_a;
    logic [3:0]      r_be;
    logic [31:0]     r_wdata;
    logic [2:0]      r_mode;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]     r_load_data;

    logic            w_acc;
    logic            w_is_byte;
    logic            w_is_half;
    logic [1:0]      w_a;
    logic [3:0]      w_be;
    logic [31:0]     w_wdata;
    logic            w_misalign;
    logic            w_timeout;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [31:0]     w_load_ext;

    assign w_acc     = memRead_M | memWrite_M;
    assign w_a       = alu_rsl_M[1:0];
    // mode[1:0]: 00 byte, 01 half, anything else (incl. undefined codes) word.
    assign w_is_byte = (mode_M[1:0] == 2'b00);
    assign w_is_half = (mode_M[1:0] == 2'b01);
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

`ifdef MISALIGN_TRAP_EN
    assign w_misalign = (w_is_half & w_a[0]) | (~w_is_byte & ~w_is_half & (w_a != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    // Lane enables and replicated store data.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = write_Data_M;
        if (w_is_byte) begin
            w_be    = 4'b0001 << w_a;
            w_wdata = {4{write_Data_M[7:0]}};
        end else if (w_is_half) begin
            w_be    = w_a[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{write_Data_M[15:0]}};
        end
    end

    // Load lane select and extension, using the mode/offset latched at issue.
    always_comb begin
        w_byte = dmem_rdata[7:0];
        unique case (r_a)
            2'd0: w_byte = dmem_rdata[7:0];
            2'd1: w_byte = dmem_rdata[15:8];
            2'd2: w_byte = dmem_rdata[23:16];
            2'd3: w_byte = dmem_rdata[31:24];
            default: w_byte = dmem_rdata[7:0];
        endcase
        w_half     = r_a[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        w_load_ext = dmem_rdata;
        if (r_mode[1:0] == 2'b00) begin
            w_load_ext = {{24{w_byte[7] & ~r_mode[2]}}, w_byte};
        end else if (r_mode[1:0] == 2'b01) begin
            w_load_ext = {{16{w_half[15] & ~r_mode[2]}}, w_half};
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_acc) w_state_next = w_misalign ? StDone : StWait;
            end
            StWait: begin
                if (dmem_ack || w_timeout) w_state_next = StDone;
            end
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Request capture, wait counter and load result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we        <= 1'b0;
            r_rd        <= 1'b0;
            r_err       <= 1'b0;
            r_waddr     <= '0;
            r_a         <= '0;
            r_be        <= '0;
            r_wdata     <= '0;
            r_mode      <= '0;
            r_cnt       <= '0;
            r_load_data <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    r_err <= 1'b0;
                    r_cnt <= '0;
                    if (w_acc) begin
                        r_we    <= memWrite_M;
                        // A misaligned load never produces data.
                        r_rd    <= memRead_M & ~memWrite_M & ~w_misalign;
                        r_waddr <= alu_rsl_M[31:2];
                        r_a     <= w_a;
                        r_be    <= w_be;
                        r_wdata <= w_wdata;
                        r_mode  <= mode_M;
                    end
                end
                StWait: begin
                    if (dmem_ack) begin
                        if (r_rd) r_load_data <= w_load_ext;
                    end else if (w_timeout) begin
                        r_err       <= 1'b1;
                        r_load_data <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_err <= r_err;
                end
            endcase
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic r_mis;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mis <= 1'b0;
        end else if (r_state == StIdle) begin
            r_mis <= w_acc & w_misalign;
        end
    end

    assign misalign_M = (r_state == StDone) & r_mis;
`endif

    // Request is live exactly while waiting; async reset forces StIdle so it drops at once.
    assign dmem_req     = (r_state == StWait);
    assign dmem_we      = r_we;
    assign dmem_addr    = {r_waddr, 2'b00};
    assign dmem_be      = r_be;
    assign dmem_wdata   = r_wdata;
    assign stall_M      = (r_state == StWait) | ((r_state == StIdle) & w_acc & rst_n);
    assign load_valid_M = (r_state == StDone) & r_rd & ~r_err;
    assign bus_err_M    = (r_state == StDone) & r_err;
    assign load_data_M  = r_load_data;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: randomized self-checking bench for mem_stage_lsu.
// Expected lanes, data and timing come from a small arithmetic model of the
// access rules; the DUT runs with a short timeout so aborts are exercised.

module tb_mem_stage_lsu;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        memRead_M, memWrite_M;
    logic [2:0]  mode_M;
    logic [31:0] alu_rsl_M, write_Data_M;
    logic        stall_M, load_valid_M, bus_err_M;
    logic [31:0] load_data_M;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
`ifdef MISALIGN_TRAP_EN
    logic        misalign_M;
`endif

    int checks   = 0;
    int failures = 0;
    int req_edges = 0;
    logic req_prev = 1'b0;

    mem_stage_lsu #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .memRead_M    (memRead_M),
        .memWrite_M   (memWrite_M),
        .mode_M       (mode_M),
        .alu_rsl_M    (alu_rsl_M),
        .write_Data_M (write_Data_M),
        .stall_M      (stall_M),
        .load_data_M  (load_data_M),
        .load_valid_M (load_valid_M),
        .bus_err_M    (bus_err_M),
`ifdef MISALIGN_TRAP_EN
        .misalign_M   (misalign_M),
`endif
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_be      (dmem_be),
        .dmem_wdata   (dmem_wdata),
        .dmem_ack     (dmem_ack),
        .dmem_rdata   (dmem_rdata)
    );

    always #5 clk = ~clk;

    // Count distinct requests issued to memory.
    always @(posedge clk) begin
        if (dmem_req && !req_prev) req_edges <= req_edges + 1;
        req_prev <= dmem_req;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---- reference model ----
    function automatic int size_of(input logic [2:0] m);
        if (m == 3'd0 || m == 3'd4) return 1;
        if (m == 3'd1 || m == 3'd5) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] m, input logic [31:0] addr);
        int a = int'(addr % 4);
        if (size_of(m) == 1) return 4'(1 << a);
        if (size_of(m) == 2) return (a >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] m, input logic [31:0] wd);
        if (size_of(m) == 1) return (wd % 256) * 32'h0101_0101;
        if (size_of(m) == 2) return (wd % 65536) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] m, input logic [31:0] addr,
                                               input logic [31:0] rd);
        int a = int'(addr % 4);
        logic [31:0] v;
        if (size_of(m) == 1) begin
            v = (rd >> (8 * a)) % 256;
            if (m == 3'd0 && v >= 128) v = v + 32'hFFFF_FF00;
            return v;
        end
        if (size_of(m) == 2) begin
            v = (rd >> ((a >= 2) ? 16 : 0)) % 65536;
            if (m == 3'd1 && v >= 32768) v = v + 32'hFFFF_0000;
            return v;
        end
        return rd;
    endfunction

    function automatic bit model_misaligned(input logic [2:0] m, input logic [31:0] addr);
`ifdef MISALIGN_TRAP_EN
        int a = int'(addr % 4);
        if (size_of(m) == 2) return (a % 2) != 0;
        if (size_of(m) == 4) return a != 0;
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    // One access; ack_dly = WAIT cycle index carrying the ack (>= TO means never).
    task automatic do_access(input bit rd, input bit wr, input logic [2:0] m,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] rdata, input int ack_dly);
        bit is_load = rd && !wr;
        bit acked   = 1'b0;
        int waits   = 0;
        int edges0;
        @(negedge clk);
        memRead_M = rd; memWrite_M = wr; mode_M = m; alu_rsl_M = addr; write_Data_M = wd;
        dmem_ack = 1'b0;
        edges0 = req_edges;
        #1 check_eq("idle_stall", 32'(stall_M), 32'd1);
        if (model_misaligned(m, addr)) begin
            @(negedge clk);
`ifdef MISALIGN_TRAP_EN
            check_eq("mis_flag", 32'(misalign_M), 32'd1);
`endif
            check_eq("mis_req", 32'(dmem_req), 32'd0);
            check_eq("mis_stall", 32'(stall_M), 32'd0);
            check_eq("mis_lvalid", 32'(load_valid_M), 32'd0);
            memRead_M = 1'b0; memWrite_M = 1'b0;
            @(negedge clk);
`ifdef MISALIGN_TRAP_EN
            check_eq("mis_pulse_end", 32'(misalign_M), 32'd0);
`endif
            check_eq("mis_no_req", 32'(req_edges - edges0), 32'd0);
            return;
        end
        @(negedge clk);
        while (!acked && waits < int'(TO)) begin
            check_eq("wait_req", 32'(dmem_req), 32'd1);
            check_eq("wait_stall", 32'(stall_M), 32'd1);
            check_eq("wait_addr", dmem_addr, addr & 32'hFFFF_FFFC);
            check_eq("wait_we", 32'(dmem_we), 32'(wr));
            if (wr) begin
                check_eq("wait_be", 32'(dmem_be), 32'(model_be(m, addr)));
                check_eq("wait_wdata", dmem_wdata, model_wdata(m, wd));
            end
            if (waits == ack_dly) begin
                dmem_ack = 1'b1; dmem_rdata = rdata; acked = 1'b1;
            end
            @(negedge clk);
            dmem_ack = 1'b0;
            dmem_rdata = $urandom;
            waits++;
        end
        check_eq("wait_cycles", 32'(waits), acked ? 32'(ack_dly + 1) : 32'(TO));
        check_eq("done_stall", 32'(stall_M), 32'd0);
        check_eq("done_req", 32'(dmem_req), 32'd0);
        check_eq("done_err", 32'(bus_err_M), 32'(!acked));
        check_eq("done_lvalid", 32'(load_valid_M), 32'(is_load && acked));
        if (is_load && acked) check_eq("load_data", load_data_M, model_load(m, addr, rdata));
        if (!acked) check_eq("abort_data", load_data_M, 32'd0);
        check_eq("one_req", 32'(req_edges - edges0), 32'd1);
        memRead_M = 1'b0; memWrite_M = 1'b0;
        // A stray ack while idle must be ignored.
        dmem_ack = 1'($urandom_range(0, 1));
        @(negedge clk);
        check_eq("idle_req", 32'(dmem_req), 32'd0);
        check_eq("idle_lvalid", 32'(load_valid_M), 32'd0);
        check_eq("idle_err", 32'(bus_err_M), 32'd0);
        dmem_ack = 1'b0;
        @(negedge clk);
        check_eq("stray_ack_req", 32'(dmem_req), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        memRead_M = 1'b0; memWrite_M = 1'b0; mode_M = 3'd0;
        alu_rsl_M = '0; write_Data_M = '0; dmem_ack = 1'b0; dmem_rdata = '0;
        #12;
        check_eq("rst_req", 32'(dmem_req), 32'd0);
        check_eq("rst_stall", 32'(stall_M), 32'd0);
        check_eq("rst_ldata", load_data_M, 32'd0);
        check_eq("rst_be", 32'(dmem_be), 32'd0);
        check_eq("rst_addr", dmem_addr, 32'd0);
        check_eq("rst_wdata", dmem_wdata, 32'd0);
        check_eq("rst_lvalid", 32'(load_valid_M), 32'd0);
        check_eq("rst_err", 32'(bus_err_M), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases.
        do_access(1'b1, 1'b0, 3'd0, 32'h0000_0103, 32'd0, 32'h80FF_FF00, 0);
        do_access(1'b0, 1'b1, 3'd1, 32'h0000_0202, 32'h1234_ABCD, 32'd0, 0);
        do_access(1'b1, 1'b0, 3'd2, 32'h0000_0040, 32'd0, 32'hDEAD_BEEF, 99);
        do_access(1'b1, 1'b0, 3'd5, 32'h0000_0042, 32'd0, 32'h8765_4321, 2);
        do_access(1'b1, 1'b1, 3'd0, 32'h0000_0011, 32'h0000_00A5, 32'hFFFF_FFFF, 1);
        do_access(1'b1, 1'b0, 3'd2, 32'h0000_0002, 32'd0, 32'h1111_2222, 0);

        // Reset asserted mid-WAIT.
        @(negedge clk);
        memRead_M = 1'b1; memWrite_M = 1'b0; mode_M = 3'd2; alu_rsl_M = 32'h300;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rstw_req", 32'(dmem_req), 32'd0);
        check_eq("rstw_stall", 32'(stall_M), 32'd0);
        @(negedge clk);
        memRead_M = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rstw_idle_req", 32'(dmem_req), 32'd0);
        check_eq("rstw_idle_stall", 32'(stall_M), 32'd0);
        check_eq("rstw_idle_lvalid", 32'(load_valid_M), 32'd0);

        // Random traffic.
        for (int i = 0; i < 60; i++) begin
            int kind = $urandom_range(0, 2);
            do_access(kind != 1, kind != 0, 3'($urandom_range(0, 7)), $urandom, $urandom,
                      $urandom, $urandom_range(0, 5));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
